// File: rtl/regfile_wr_arb.sv
// Write-port controller for the 32x32 register file: clears x1..x31 after reset,
// then arbitrates core/aux writes with fixed core priority and an aux starvation guard.
module regfile_wr_arb #(
  parameter int MAX_WAIT     = 4,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_valid,
  input  logic [4:0]  core_addr,
  input  logic [31:0] core_data,
  output logic        core_ready,
  input  logic        aux_valid,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  output logic        aux_ready,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic        init_done
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [4:0]       clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             we3_q, we3_d;
  logic [4:0]       a3_q, a3_d;
  logic [31:0]      wd3_q, wd3_d;
  logic             init_done_q, init_done_d;

  logic in_run;
  logic starve;
  logic core_gnt;
  logic aux_gnt;

  // Readies depend only on state, the starvation counter and the other port's valid.
  always_comb begin
    in_run     = (state_q == ST_RUN);
    starve     = (wait_cnt_q == WAIT_MAX);
    core_ready = in_run & ~starve;
    aux_ready  = in_run & (starve | ~core_valid);
    core_gnt   = core_valid & core_ready;
    aux_gnt    = aux_valid & aux_ready;
  end

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    wait_cnt_d  = wait_cnt_q;
    we3_d       = 1'b0;
    a3_d        = a3_q;
    wd3_d       = wd3_q;
    init_done_d = init_done_q;

    case (state_q)
      ST_INIT: begin
        we3_d      = 1'b1;
        a3_d       = clr_idx_q;
        wd3_d      = 32'd0;
        clr_idx_d  = clr_idx_q + 5'd1;
        wait_cnt_d = '0;
        if (clr_idx_q == 5'd31) begin
          init_done_d = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: begin
        // x0 writes complete the handshake but never strobe the file.
        if (core_gnt) begin
          we3_d = |core_addr;
          a3_d  = core_addr;
          wd3_d = core_data;
        end else if (aux_gnt) begin
          we3_d = |aux_addr;
          a3_d  = aux_addr;
          wd3_d = aux_data;
        end

        if (!aux_valid || aux_ready) begin
          wait_cnt_d = '0;
        end else if (!starve) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLR_ON_RESET ? ST_INIT : ST_RUN;
      clr_idx_q   <= 5'd1;
      wait_cnt_q  <= '0;
      we3_q       <= 1'b0;
      a3_q        <= 5'd0;
      wd3_q       <= 32'd0;
      init_done_q <= ~CLR_ON_RESET;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      we3_q       <= we3_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      init_done_q <= init_done_d;
    end
  end

  assign we3       = we3_q;
  assign a3        = a3_q;
  assign wd3       = wd3_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Bench for regfile_wr_arb: clear sequence, directed vector table, starvation and
// mid-INIT reset sequences, then randomized traffic against a request-level model.
module tb_regfile_wr_arb;

  localparam int MW = 4;

  logic        clk;
  logic        rst_n;
  logic        core_valid;
  logic [4:0]  core_addr;
  logic [31:0] core_data;
  logic        core_ready;
  logic        aux_valid;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        init_done;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wr_arb #(.MAX_WAIT(MW), .CLR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_valid(core_valid), .core_addr(core_addr), .core_data(core_data), .core_ready(core_ready),
    .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_data(aux_data), .aux_ready(aux_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in driven by the DUT's write port; x0 deliberately unguarded.
  logic [31:0] rf [32];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : 32'(i * 7 + 1);
    end else if (we3) begin
      rf[a3] <= wd3;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [4:0] ca, input logic [31:0] cd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    core_valid = cv; core_addr = ca; core_data = cd;
    aux_valid  = av; aux_addr  = aa; aux_data  = ad;
  endtask

  // Expects rst_n to have just been released; checks the 31-cycle clear.
  task automatic clear_seq();
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("clr_we3", 32'(we3), 32'd1);
      chk("clr_a3", 32'(a3), 32'(i));
      chk("clr_wd3", wd3, 32'd0);
      chk("clr_init_done", 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
    end
    $display("clear sequence x1..x31 observed");
  endtask

  typedef struct {
    logic        cv;
    logic [4:0]  ca;
    logic [31:0] cd;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        ecr;
    logic        ear;
    logic        ewe;
    logic [4:0]  ea3;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl [11];

  // Random-phase model state
  logic [31:0] exp_rf [32];
  int          aux_age;
  logic        exp_we;
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd;
  bit          found;

  initial begin
    tbl[0]  = '{1'b1, 5'd1,  32'd400,        1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b1, 5'd1,  32'd400};
    tbl[1]  = '{1'b1, 5'd2,  32'd500,        1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b1, 5'd2,  32'd500};
    tbl[2]  = '{1'b1, 5'd3,  32'd600,        1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b1, 5'd3,  32'd600};
    tbl[3]  = '{1'b1, 5'd4,  32'd700,        1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b1, 5'd4,  32'd700};
    tbl[4]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0, 32'd0,  1'b1, 1'b1, 1'b0, 5'd4,  32'd700};
    tbl[5]  = '{1'b0, 5'd0,  32'd0,          1'b1, 5'd7, 32'd123,1'b1, 1'b1, 1'b1, 5'd7,  32'd123};
    tbl[6]  = '{1'b1, 5'd0,  32'hFFFF_FFFF,  1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, 5'd0,  32'hFFFF_FFFF};
    tbl[7]  = '{1'b1, 5'd8,  32'd11,         1'b1, 5'd9, 32'd22, 1'b1, 1'b0, 1'b1, 5'd8,  32'd11};
    tbl[8]  = '{1'b1, 5'd10, 32'd33,         1'b1, 5'd9, 32'd22, 1'b1, 1'b0, 1'b1, 5'd10, 32'd33};
    tbl[9]  = '{1'b0, 5'd0,  32'd0,          1'b1, 5'd9, 32'd22, 1'b1, 1'b1, 1'b1, 5'd9,  32'd22};
    tbl[10] = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0, 32'd0,  1'b1, 1'b1, 1'b0, 5'd9,  32'd22};

    // Reset with preload of nonzero register contents
    rst_n = 1'b0;
    preload = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    preload = 1'b0;
    core_valid = 1'b1;
    tick();
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_a3", 32'(a3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_core_ready", 32'(core_ready), 32'd0);
    chk("rst_aux_ready", 32'(aux_ready), 32'd0);
    chk("pre_rf5", rf[5], 32'd36);
    core_valid = 1'b0;
    rst_n = 1'b1;
    clear_seq();
    tick();
    chk("post_clr_we3", 32'(we3), 32'd0);
    for (int i = 0; i < 32; i++) chk("clr_rf_zero", rf[i], 32'd0);

    // Directed vector table
    for (int v = 0; v < 11; v++) begin
      drive(tbl[v].cv, tbl[v].ca, tbl[v].cd, tbl[v].av, tbl[v].aa, tbl[v].ad);
      #1;
      chk("vec_core_ready", 32'(core_ready), 32'(tbl[v].ecr));
      chk("vec_aux_ready", 32'(aux_ready), 32'(tbl[v].ear));
      @(posedge clk);
      #1;
      chk("vec_we3", 32'(we3), 32'(tbl[v].ewe));
      chk("vec_a3", 32'(a3), 32'(tbl[v].ea3));
      chk("vec_wd3", wd3, tbl[v].ewd);
      $display("vec %0d: we3=%0b a3=%0d wd3=%0h", v, we3, a3, wd3);
    end
    chk("rf_x1", rf[1], 32'd400);
    chk("rf_x2", rf[2], 32'd500);
    chk("rf_x3", rf[3], 32'd600);
    chk("rf_x4", rf[4], 32'd700);
    chk("rf_x7", rf[7], 32'd123);
    chk("rf_x0", rf[0], 32'd0);
    chk("rf_x8", rf[8], 32'd11);
    chk("rf_x9", rf[9], 32'd22);
    chk("rf_x10", rf[10], 32'd33);

    // Contention: core wins MW cycles, aux wins the next one
    for (int c = 1; c <= MW + 1; c++) begin
      drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'hDEAD);
      #1;
      chk("cont_core_ready", 32'(core_ready), (c <= MW) ? 32'd1 : 32'd0);
      chk("cont_aux_ready", 32'(aux_ready), (c <= MW) ? 32'd0 : 32'd1);
      tick();
      chk("cont_we3", 32'(we3), 32'd1);
      chk("cont_a3", 32'(a3), (c <= MW) ? 32'd5 : 32'd6);
      chk("cont_wd3", wd3, (c <= MW) ? 32'h55 : 32'hDEAD);
      $display("contention cycle %0d: a3=%0d wd3=%0h", c, a3, wd3);
    end
    #1;
    chk("cont_after_core_ready", 32'(core_ready), 32'd1);
    chk("cont_after_aux_ready", 32'(aux_ready), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("rf_x6", rf[6], 32'hDEAD);

    // Randomized traffic against a request-level model
    for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
    aux_age = 0;
    exp_we = 1'b0; exp_a3 = 5'd5; exp_wd = 32'h55;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic cg, ag, ecr, ear;
      if (!core_valid && $urandom_range(0, 9) < 7) begin
        core_valid = 1'b1; core_addr = 5'($urandom_range(0, 31)); core_data = $urandom;
      end
      if (!aux_valid && $urandom_range(0, 9) < 5) begin
        aux_valid = 1'b1; aux_addr = 5'($urandom_range(0, 31)); aux_data = $urandom;
      end
      #1;
      // Aux takes the port once it has been refused MW times in a row, or when core is idle.
      ecr = !(aux_age >= MW);
      ear = (aux_age >= MW) || !core_valid;
      chk("rnd_core_ready", 32'(core_ready), 32'(ecr));
      chk("rnd_aux_ready", 32'(aux_ready), 32'(ear));
      cg = core_valid && ecr;
      ag = aux_valid && ear && !cg;
      if (cg) begin
        exp_we = (core_addr != 5'd0); exp_a3 = core_addr; exp_wd = core_data;
        if (core_addr != 5'd0) exp_rf[core_addr] = core_data;
      end else if (ag) begin
        exp_we = (aux_addr != 5'd0); exp_a3 = aux_addr; exp_wd = aux_data;
        if (aux_addr != 5'd0) exp_rf[aux_addr] = aux_data;
      end else begin
        exp_we = 1'b0;
      end
      aux_age = (aux_valid && !ag) ? aux_age + 1 : 0;
      @(posedge clk);
      #1;
      chk("rnd_we3", 32'(we3), 32'(exp_we));
      chk("rnd_a3", 32'(a3), 32'(exp_a3));
      chk("rnd_wd3", wd3, exp_wd);
      if (cg || ag) $display("rnd %0d: %s grant a3=%0d wd3=%0h", cyc, cg ? "core" : "aux", a3, wd3);
      if (cg) core_valid = 1'b0;
      if (ag) aux_valid = 1'b0;
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    for (int i = 0; i < 32; i++) chk("rnd_rf", rf[i], exp_rf[i]);

    // Reset mid-INIT
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (we3 && a3 == 5'd10) found = 1'b1;
    end
    chk("midinit_reached_a3_10", 32'(found), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midinit_we3", 32'(we3), 32'd0);
    chk("midinit_init_done", 32'(init_done), 32'd0);
    chk("midinit_a3", 32'(a3), 32'd0);
    rst_n = 1'b1;
    clear_seq();
    tick();
    chk("midinit_post_we3", 32'(we3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
